// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: state encoding and default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_stage_pkg;

    // Default datapath width.
    localparam int DW_DEFAULT = 32;

    // Register-number width.
    localparam int REG_AW = 5;

    // Data-memory interface FSM states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/dmem_if_fsm.sv
// Data-memory handshake tracker: wait-state FSM, timeout counter, sticky bus error, stall.
// Latency: stall/done/timeout are combinational from state and dmem_ready; state updates next edge.
// Backpressure: stall_o holds the pipeline while an access is outstanding and not yet done.
module dmem_if_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic memop_i,
    input  logic ready_i,
    output logic timeout_o,
    output logic done_o,
    output logic stall_o,
    output logic bus_err_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;

    // Access completes on ready, or is forced complete after the last allowed wait cycle.
    always_comb begin
        timeout_o = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
        done_o    = ready_i || timeout_o;
        stall_o   = memop_i && !done_o;
        bus_err_o = bus_err_q;
    end

    // Next state: enter WAIT only when the request is not answered in its first cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q | timeout_o;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (memop_i && !ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_o) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and sticky error registers; only reset clears the error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM and MEM/WB registers around a data-memory request/ready handshake.
// Latency: 1 cycle E->M, 1 cycle M->W, plus one stall cycle per memory wait state.
// Backpressure: StallMem freezes M and inserts W bubbles until the access completes or times out.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int DW      = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     ALUOutE,
    input  logic [DW-1:0]     WriteDataE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemReadE,
    input  logic              MemWriteE,
    output logic [DW-1:0]     ALUOutM,
    output logic [REG_AW-1:0] WriteRegM,
    output logic              RegWriteM,
    output logic [DW-1:0]     ResultW,
    output logic [REG_AW-1:0] WriteRegW,
    output logic              RegWriteW,
    output logic              StallMem,
    output logic              BusErr,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DW-1:0]     dmem_addr,
    output logic [DW-1:0]     dmem_wdata,
    input  logic [DW-1:0]     dmem_rdata,
    input  logic              dmem_ready
);

    // EX/MEM fields
    logic [DW-1:0]     alu_m_q, alu_m_d;
    logic [DW-1:0]     wdata_m_q, wdata_m_d;
    logic [REG_AW-1:0] wreg_m_q, wreg_m_d;
    logic              regwrite_m_q, regwrite_m_d;
    logic              memtoreg_m_q, memtoreg_m_d;
    logic              memread_m_q, memread_m_d;
    logic              memwrite_m_q, memwrite_m_d;

    // MEM/WB fields
    logic [DW-1:0]     alu_w_q, alu_w_d;
    logic [DW-1:0]     rdata_w_q, rdata_w_d;
    logic [REG_AW-1:0] wreg_w_q, wreg_w_d;
    logic              regwrite_w_q, regwrite_w_d;
    logic              memtoreg_w_q, memtoreg_w_d;

    logic memop;
    logic timeout;
    logic done;
    logic stall;

    assign memop = memread_m_q | memwrite_m_q;

    dmem_if_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .memop_i   (memop),
        .ready_i   (dmem_ready),
        .timeout_o (timeout),
        .done_o    (done),
        .stall_o   (stall),
        .bus_err_o (BusErr)
    );

    // Bus and forwarding outputs come straight from the M registers, so they hold during a stall.
    always_comb begin
        dmem_req   = memop;
        dmem_we    = memwrite_m_q;
        dmem_addr  = alu_m_q;
        dmem_wdata = wdata_m_q;
        ALUOutM    = alu_m_q;
        WriteRegM  = wreg_m_q;
        RegWriteM  = regwrite_m_q;
        StallMem   = stall;
        WriteRegW  = wreg_w_q;
        RegWriteW  = regwrite_w_q;
        ResultW    = memtoreg_w_q ? rdata_w_q : alu_w_q;
    end

    // Next state: M holds and W takes a bubble while stalled; a timed-out load returns zero.
    always_comb begin
        alu_m_d      = alu_m_q;
        wdata_m_d    = wdata_m_q;
        wreg_m_d     = wreg_m_q;
        regwrite_m_d = regwrite_m_q;
        memtoreg_m_d = memtoreg_m_q;
        memread_m_d  = memread_m_q;
        memwrite_m_d = memwrite_m_q;
        alu_w_d      = alu_w_q;
        rdata_w_d    = rdata_w_q;
        wreg_w_d     = wreg_w_q;
        regwrite_w_d = 1'b0;
        memtoreg_w_d = memtoreg_w_q;
        if (!stall) begin
            alu_m_d      = ALUOutE;
            wdata_m_d    = WriteDataE;
            wreg_m_d     = WriteRegE;
            regwrite_m_d = RegWriteE;
            memtoreg_m_d = MemtoRegE;
            memread_m_d  = MemReadE;
            memwrite_m_d = MemWriteE;
            alu_w_d      = alu_m_q;
            rdata_w_d    = timeout ? '0 : dmem_rdata;
            wreg_w_d     = wreg_m_q;
            regwrite_w_d = regwrite_m_q;
            memtoreg_w_d = memtoreg_m_q;
        end
    end

    // Pipeline registers with synchronous reset to all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_m_q      <= '0;
            wdata_m_q    <= '0;
            wreg_m_q     <= '0;
            regwrite_m_q <= 1'b0;
            memtoreg_m_q <= 1'b0;
            memread_m_q  <= 1'b0;
            memwrite_m_q <= 1'b0;
            alu_w_q      <= '0;
            rdata_w_q    <= '0;
            wreg_w_q     <= '0;
            regwrite_w_q <= 1'b0;
            memtoreg_w_q <= 1'b0;
        end else begin
            alu_m_q      <= alu_m_d;
            wdata_m_q    <= wdata_m_d;
            wreg_m_q     <= wreg_m_d;
            regwrite_m_q <= regwrite_m_d;
            memtoreg_m_q <= memtoreg_m_d;
            memread_m_q  <= memread_m_d;
            memwrite_m_q <= memwrite_m_d;
            alu_w_q      <= alu_w_d;
            rdata_w_q    <= rdata_w_d;
            wreg_w_q     <= wreg_w_d;
            regwrite_w_q <= regwrite_w_d;
            memtoreg_w_q <= memtoreg_w_d;
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline, consuming the execute-stage outputs.
- Contains the EX/MEM and MEM/WB pipeline registers and a data-memory request/ready handshake with a wait-state FSM and timeout.
- Produces the forwarding sources ALUOutM and ResultW that feed back into execute.
- Raises StallMem to the hazard unit while a memory access is outstanding.

Parameters:
- TIMEOUT, 255: maximum cycles spent in WAIT before the access is force-completed; must be ≥1.
- DW, 32: datapath width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ALUOutE  in  DW  execute ALU result / memory address.
- WriteDataE  in  DW  store data (forwarded rt).
- WriteRegE  in  5  destination register.
- RegWriteE  in  1  instruction writes the register file.
- MemtoRegE  in  1  write-back selects memory data.
- MemReadE  in  1  load.
- MemWriteE  in  1  store.
- ALUOutM  out  DW  registered ALU result; forwarding source.
- WriteRegM  out  5  destination register in M; used by the hazard unit.
- RegWriteM  out  1  register-write flag in M; used by the hazard unit.
- ResultW  out  DW  write-back value; forwarding source.
- WriteRegW  out  5  register-file write address.
- RegWriteW  out  1  register-file write enable.
- StallMem  out  1  memory access pending; the hazard unit freezes F/D/E.
- BusErr  out  1  sticky timeout flag.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DW  byte address (word access).
- dmem_wdata  out  DW  store data.
- dmem_rdata  in  DW  load data; valid when dmem_ready=1.
- dmem_ready  in  1  access complete this cycle.

Behaviour:
- Reset (synchronous):
  - All EX/MEM and MEM/WB fields go to 0.
  - FSM goes to IDLE; wait counter goes to 0; BusErr goes to 0.
  - Consequently every output reads 0 after the reset edge, including dmem_req and StallMem.
- Definitions (all combinational):
  - memop = MemReadM | MemWriteM.
  - timeout = (state==WAIT) & (cnt==TIMEOUT-1).
  - done = dmem_ready | timeout.
  - StallMem = memop & ~done.
- Bus outputs (combinational from M registers):
  - dmem_req = memop.
  - dmem_we = MemWriteM.
  - dmem_addr = ALUOutM.
  - dmem_wdata = WriteDataM.
  - These are stable for the whole request because M holds while StallMem=1.
- EX/MEM register:
  - StallMem=0: load all E inputs.
  - StallMem=1: hold.
  - The hazard unit must keep the E inputs stable while StallMem=1.
- MEM/WB register:
  - StallMem=0: load ALUOutW<=ALUOutM, WriteRegW<=WriteRegM, RegWriteW<=RegWriteM, MemtoRegW<=MemtoRegM, ReadDataW<=(timeout ? 0 : dmem_rdata).
  - StallMem=1: insert a bubble (RegWriteW<=0); other W fields are don't-care.
- ResultW = MemtoRegW ? ReadDataW : ALUOutW (combinational).
- FSM:
  - IDLE → WAIT when memop & ~dmem_ready. Zero-wait access: ready in the request cycle means no stall and no WAIT entry.
  - WAIT → IDLE when done; cnt increments each WAIT cycle and clears in IDLE.
- Timeout:
  - Completes the access: load data 0, store dropped by the slave.
  - Sets BusErr; BusErr clears only on rst.
- dmem_ready while dmem_req=0 is ignored.
- MemReadE and MemWriteE both set: treated as a write (dmem_we=1); MemtoReg still selects dmem_rdata.
- Back-to-back memory ops: the second request is issued the cycle after the first completes; there is no idle gap requirement.
- Reset mid-access: M clears at the edge, so dmem_req drops the next cycle and the pending access is abandoned; the slave must tolerate a dropped request.
- Latency: one cycle E→M and one cycle M→W; a memory access adds N stall cycles for N wait states.

Decomposition:
- Shared pipeline package holds:
  - FSM state encoding (IDLE=0, WAIT=1);
  - the DW default;
  - register-number width (5).
- Natural sub-module: dmem_if_fsm, containing the FSM, wait counter, timeout, BusErr, StallMem and done. The pipeline registers stay in mem_stage.

Test Plan:
- Reset check: assert rst with all E inputs = 1s → all outputs 0 the next cycle; dmem_req=0.
- ALU pass-through: ALUOutE=0x1234, RegWriteE=1, WriteRegE=5, no memop → ALUOutM=0x1234 after 1 clock; ResultW=0x1234, WriteRegW=5, RegWriteW=1 after 2 clocks; StallMem never asserted.
- Zero-wait load: MemReadE=1, MemtoRegE=1, ALUOutE=0x40, slave returns rdata=0xDEADBEEF with ready in the same cycle → dmem_addr=0x40, no stall, ResultW=0xDEADBEEF one cycle later.
- 3-wait-state store: MemWriteE=1, WriteDataE=0xA5A5, ready arrives on the 4th request cycle → StallMem high for 3 cycles, req/we/addr/wdata stable throughout, M held, RegWriteW=0 during the bubbles.
- Timeout: TIMEOUT=4, load with ready never asserted → StallMem deasserts on the 4th WAIT cycle, ReadDataW=0, BusErr=1 and stays 1 until rst.
- Reset mid-wait: rst asserted in the 2nd WAIT cycle → FSM IDLE, dmem_req=0 and StallMem=0 the next cycle, BusErr=0.
